ddr2_write_path_sched: RTL and testbench

//  Parametrised DDR2 write data path scheduler.
//  - Accepts write-burst commands and waits a runtime write latency (WL).
//  - Pops one rise/fall beat per cycle from the write-data FIFO (show-ahead).
//  - Emits DQS preamble/enable, DQ output enable and registered rise/fall data and mask to the IOB layer.
//  - Supports BL4/BL8, seamless back-to-back bursts and FIFO-underrun protection.

---
 rtl/ddr2_write_path_sched.sv | 128 ++++++++++++
 tb/tb_ddr2_write_path_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_write_path_sched.sv
// DDR2 write data path scheduler: turns accepted write-burst commands into FIFO pops,
// DQS preamble/enable, DQ output enable and registered rise/fall data for the IOB layer.
module ddr2_write_path_sched #(
  parameter int DQ_WIDTH = 16,
  parameter int DM_WIDTH = 2,
  parameter int MAX_WL   = 8,
  parameter int WL_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WL_W-1:0]       cfg_wl,
  input  logic                  cfg_bl8,
  input  logic                  wr_cmd_valid,
  output logic                  wr_cmd_ready,
  input  logic [2*DQ_WIDTH-1:0] wdf_data,
  input  logic [2*DM_WIDTH-1:0] mask_data,
  input  logic                  wdf_empty,
  output logic                  wdf_rden,
  output logic                  dqs_rst,
  output logic                  dqs_en,
  output logic                  wr_en,
  output logic                  dq_oe,
  output logic [DQ_WIDTH-1:0]   wr_data_rise,
  output logic [DQ_WIDTH-1:0]   wr_data_fall,
  output logic [DM_WIDTH-1:0]   mask_data_rise,
  output logic [DM_WIDTH-1:0]   mask_data_fall,
  output logic                  underrun,
  output logic                  busy
);

  localparam int SCHED_W = MAX_WL + 4;

  // Bit i of sched_q marks a pop slot i cycles from now; bit 0 is the current cycle.
  logic [SCHED_W-1:0]    sched_q, sched_d, burst_mask;
  logic [1:0]            hold_q, hold_d;
  logic                  wr_en_q, wr_en_d;
  logic                  oe_tail_q, oe_tail_d;
  logic                  dqs_prev_q, dqs_prev_d;
  logic                  oe_prev_q, oe_prev_d;
  logic                  underrun_q, underrun_d;
  logic [DQ_WIDTH-1:0]   rise_q, rise_d, fall_q, fall_d;
  logic [DM_WIDTH-1:0]   mrise_q, mrise_d, mfall_q, mfall_d;
  logic                  cmd_fire, pop_slot;
  logic [WL_W:0]         wl_ext, wl_end;

  assign wr_cmd_ready = (hold_q == 2'd0);
  assign cmd_fire     = wr_cmd_valid & wr_cmd_ready;
  assign wl_ext       = {1'b0, cfg_wl};
  assign wl_end       = wl_ext + (cfg_bl8 ? (WL_W+1)'(4) : (WL_W+1)'(2));

  // Accepted at T0, beat k pops in T0+WL-1+k, which is bit WL-2+k of the next-cycle vector.
  for (genvar gi = 0; gi < SCHED_W; gi++) begin : g_mask
    localparam logic [WL_W:0] POS = (WL_W+1)'(gi + 2);
    assign burst_mask[gi] = cmd_fire && (POS >= wl_ext) && (POS < wl_end);
  end

  assign pop_slot = sched_q[0];
  assign wdf_rden = pop_slot & ~wdf_empty;
  assign dqs_en   = pop_slot | wr_en_q;
  assign dqs_rst  = pop_slot & ~dqs_prev_q;
  assign wr_en    = wr_en_q;
  assign dq_oe    = dqs_en | oe_tail_q;
  assign busy     = cmd_fire | (|sched_q) | dq_oe | oe_prev_q;
  assign underrun = underrun_q;

  assign wr_data_rise   = rise_q;
  assign wr_data_fall   = fall_q;
  assign mask_data_rise = mrise_q;
  assign mask_data_fall = mfall_q;

  always_comb begin
    sched_d    = {1'b0, sched_q[SCHED_W-1:1]} | burst_mask;
    hold_d     = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
    wr_en_d    = pop_slot;
    oe_tail_d  = wr_en_q;
    dqs_prev_d = dqs_en;
    oe_prev_d  = dq_oe;
    underrun_d = underrun_q | (pop_slot & wdf_empty);
    rise_d     = rise_q;
    fall_d     = fall_q;
    mrise_d    = mrise_q;
    mfall_d    = mfall_q;
    if (cmd_fire) begin
      hold_d = cfg_bl8 ? 2'd3 : 2'd1;
    end
    if (pop_slot) begin
      if (wdf_empty) begin
        // Starved beat still goes out, but fully masked so memory is untouched.
        rise_d  = '0;
        fall_d  = '0;
        mrise_d = '1;
        mfall_d = '1;
      end else begin
        {rise_d, fall_d}   = wdf_data;
        {mrise_d, mfall_d} = mask_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sched_q    <= '0;
      hold_q     <= '0;
      wr_en_q    <= 1'b0;
      oe_tail_q  <= 1'b0;
      dqs_prev_q <= 1'b0;
      oe_prev_q  <= 1'b0;
      underrun_q <= 1'b0;
      rise_q     <= '0;
      fall_q     <= '0;
      mrise_q    <= '0;
      mfall_q    <= '0;
    end else begin
      sched_q    <= sched_d;
      hold_q     <= hold_d;
      wr_en_q    <= wr_en_d;
      oe_tail_q  <= oe_tail_d;
      dqs_prev_q <= dqs_prev_d;
      oe_prev_q  <= oe_prev_d;
      underrun_q <= underrun_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      mrise_q    <= mrise_d;
      mfall_q    <= mfall_d;
    end
  end

endmodule

// File: tb/tb_ddr2_write_path_sched.sv
// Directed bench for ddr2_write_path_sched: per-cycle control/data expectations for
// single bursts, seamless and one-gap bursts, underrun, mid-burst reset and mask pass-through.
module tb_ddr2_write_path_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  cfg_wl = 4'd2;
  logic        cfg_bl8 = 1'b0;
  logic        wr_cmd_valid = 1'b0;
  logic        wr_cmd_ready;
  logic [31:0] wdf_data;
  logic [3:0]  mask_data;
  logic        wdf_empty;
  logic        wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, underrun, busy;
  logic [15:0] wr_data_rise, wr_data_fall;
  logic [1:0]  mask_data_rise, mask_data_fall;

  int checks = 0;
  int failures = 0;

  // Show-ahead FIFO model
  logic [31:0] mem_data [256];
  logic [3:0]  mem_mask [256];
  logic [7:0]  rd_ptr = 8'd0;
  logic [7:0]  wr_ptr = 8'd0;
  logic        force_empty = 1'b0;
  int          pop_cnt = 0;

  assign wdf_data  = mem_data[rd_ptr];
  assign mask_data = mem_mask[rd_ptr];
  assign wdf_empty = (rd_ptr == wr_ptr) | force_empty;

  always @(posedge clk) begin
    if (wdf_rden) begin
      rd_ptr  <= rd_ptr + 8'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  always #5 clk = ~clk;

  ddr2_write_path_sched #(.DQ_WIDTH(16), .DM_WIDTH(2), .MAX_WL(8), .WL_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_wl(cfg_wl), .cfg_bl8(cfg_bl8),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wdf_data(wdf_data), .mask_data(mask_data), .wdf_empty(wdf_empty),
    .wdf_rden(wdf_rden), .dqs_rst(dqs_rst), .dqs_en(dqs_en), .wr_en(wr_en),
    .dq_oe(dq_oe), .wr_data_rise(wr_data_rise), .wr_data_fall(wr_data_fall),
    .mask_data_rise(mask_data_rise), .mask_data_fall(mask_data_fall),
    .underrun(underrun), .busy(busy)
  );

  task automatic fifo_flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic fifo_push(input logic [31:0] d, input logic [3:0] m);
    mem_data[wr_ptr] = d;
    mem_mask[wr_ptr] = m;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic test_reset();
    logic [6:0] exp_ctl;
    @(negedge clk);
    #1;
    checks++;
    if ({wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, underrun, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctl actual=%b required=0000000",
               {wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, underrun, busy});
    end
    checks++;
    if ({wr_data_rise, wr_data_fall, mask_data_rise, mask_data_fall} !== 36'h0) begin
      failures++;
      $display("FAIL reset_data actual=%h required=0", {wr_data_rise, wr_data_fall, mask_data_rise, mask_data_fall});
    end
    checks++;
    if (wr_cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready actual=%b required=1", wr_cmd_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_ctl = 7'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, underrun, busy} !== exp_ctl) begin
      failures++;
      $display("FAIL post_reset_ctl actual=%b required=%b",
               {wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, underrun, busy}, exp_ctl);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_bl4();
    logic [5:0] exp_ctl;
    fifo_flush();
    fifo_push({16'hA1A1, 16'hA0A0}, 4'h0);
    fifo_push({16'hB1B1, 16'hB0B0}, 4'h0);
    cfg_wl = 4'd3; cfg_bl8 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      wr_cmd_valid = (c == 0);
      #1;
      exp_ctl = {(c >= 2 && c <= 3), (c == 2), (c >= 2 && c <= 4), (c >= 3 && c <= 4),
                 (c >= 2 && c <= 5), (c != 1)};
      checks++;
      if ({wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, wr_cmd_ready} !== exp_ctl) begin
        failures++;
        $display("FAIL basic_ctl c=%0d actual=%b required=%b (rden,rst,dqs,wr,oe,rdy)",
                 c, {wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, wr_cmd_ready}, exp_ctl);
      end
      if (c == 3 || c == 4) begin
        checks++;
        if ({wr_data_rise, wr_data_fall} !== ((c == 3) ? {16'hA1A1, 16'hA0A0} : {16'hB1B1, 16'hB0B0})) begin
          failures++;
          $display("FAIL basic_data c=%0d actual=%h", c, {wr_data_rise, wr_data_fall});
        end
      end
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL basic_busy actual=%b required=1", busy);
        end
      end
    end
    wr_cmd_valid = 1'b0;
    $display("test_basic_bl4 done");
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_ctl;
    int pops0;
    fifo_flush();
    for (int k = 0; k < 8; k++) fifo_push({16'(16'h2000 + k), 16'(16'h2100 + k)}, 4'h0);
    cfg_wl = 4'd5; cfg_bl8 = 1'b1;
    pops0 = pop_cnt;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      wr_cmd_valid = (c == 0 || c == 4);
      #1;
      exp_ctl = {(c >= 4 && c <= 11), (c == 4), (c >= 4 && c <= 12), (c >= 5 && c <= 12),
                 (c >= 4 && c <= 13), !((c >= 1 && c <= 3) || (c >= 5 && c <= 7))};
      checks++;
      if ({wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, wr_cmd_ready} !== exp_ctl) begin
        failures++;
        $display("FAIL seamless_ctl c=%0d actual=%b required=%b (rden,rst,dqs,wr,oe,rdy)",
                 c, {wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, wr_cmd_ready}, exp_ctl);
      end
      if (c >= 5 && c <= 12) begin
        checks++;
        if ({wr_data_rise, wr_data_fall} !== {16'(16'h2000 + c - 5), 16'(16'h2100 + c - 5)}) begin
          failures++;
          $display("FAIL seamless_data c=%0d actual=%h", c, {wr_data_rise, wr_data_fall});
        end
      end
    end
    wr_cmd_valid = 1'b0;
    checks++;
    if (pop_cnt - pops0 !== 8) begin
      failures++;
      $display("FAIL seamless_pops actual=%0d required=8", pop_cnt - pops0);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_one_gap();
    logic [5:0] exp_ctl;
    fifo_flush();
    for (int k = 0; k < 4; k++) fifo_push({16'(16'h3000 + k), 16'(16'h3100 + k)}, 4'h0);
    cfg_wl = 4'd2; cfg_bl8 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      wr_cmd_valid = (c == 0 || c == 3);
      #1;
      exp_ctl = {(c == 1 || c == 2 || c == 4 || c == 5), (c == 1), (c >= 1 && c <= 6),
                 (c == 2 || c == 3 || c == 5 || c == 6), (c >= 1 && c <= 7), !(c == 1 || c == 4)};
      checks++;
      if ({wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, wr_cmd_ready} !== exp_ctl) begin
        failures++;
        $display("FAIL gap_ctl c=%0d actual=%b required=%b (rden,rst,dqs,wr,oe,rdy)",
                 c, {wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, wr_cmd_ready}, exp_ctl);
      end
      if (c == 6) begin
        checks++;
        if ({wr_data_rise, wr_data_fall} !== {16'h3003, 16'h3103}) begin
          failures++;
          $display("FAIL gap_data actual=%h required=30033103", {wr_data_rise, wr_data_fall});
        end
      end
    end
    wr_cmd_valid = 1'b0;
    $display("test_one_gap done");
  endtask

  task automatic test_underrun();
    logic [5:0]  exp_ctl;
    logic [35:0] exp_dat;
    int pops0;
    fifo_flush();
    for (int k = 0; k < 3; k++) fifo_push({16'(16'h4000 + k), 16'(16'h4100 + k)}, 4'h0);
    cfg_wl = 4'd4; cfg_bl8 = 1'b1;
    pops0 = pop_cnt;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      wr_cmd_valid = (c == 0);
      force_empty  = (c == 5);
      #1;
      exp_ctl = {(c == 3 || c == 4 || c == 6), (c == 3), (c >= 3 && c <= 7), (c >= 4 && c <= 7),
                 (c >= 3 && c <= 8), (c >= 6)};
      checks++;
      if ({wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, underrun} !== exp_ctl) begin
        failures++;
        $display("FAIL underrun_ctl c=%0d actual=%b required=%b (rden,rst,dqs,wr,oe,urun)",
                 c, {wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, underrun}, exp_ctl);
      end
      if (c >= 4 && c <= 7) begin
        case (c)
          4:       exp_dat = {16'h4000, 16'h4100, 4'h0};
          5:       exp_dat = {16'h4001, 16'h4101, 4'h0};
          6:       exp_dat = {32'h0, 4'hF};
          default: exp_dat = {16'h4002, 16'h4102, 4'h0};
        endcase
        checks++;
        if ({wr_data_rise, wr_data_fall, mask_data_rise, mask_data_fall} !== exp_dat) begin
          failures++;
          $display("FAIL underrun_data c=%0d actual=%h required=%h", c,
                   {wr_data_rise, wr_data_fall, mask_data_rise, mask_data_fall}, exp_dat);
        end
      end
    end
    wr_cmd_valid = 1'b0;
    force_empty  = 1'b0;
    checks++;
    if (pop_cnt - pops0 !== 3) begin
      failures++;
      $display("FAIL underrun_pops actual=%0d required=3", pop_cnt - pops0);
    end
    $display("test_underrun done");
  endtask

  task automatic test_reset_mid_burst();
    fifo_flush();
    for (int k = 0; k < 8; k++) fifo_push({16'(16'h5000 + k), 16'(16'h5100 + k)}, 4'h0);
    cfg_wl = 4'd8; cfg_bl8 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      wr_cmd_valid = (c == 0);
    end
    @(negedge clk);
    wr_cmd_valid = 1'b0;
    #1;
    checks++;
    if ({wr_en, wdf_rden, wr_data_rise, wr_data_fall} !== {2'b11, 16'h5001, 16'h5101}) begin
      failures++;
      $display("FAIL mid_beat1 actual=%h", {wr_en, wdf_rden, wr_data_rise, wr_data_fall});
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, underrun, busy, wr_data_rise, wr_data_fall,
         mask_data_rise, mask_data_fall} !== 43'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs actual=%b", {wdf_rden, dqs_rst, dqs_en, wr_en, dq_oe, underrun, busy});
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({wdf_rden, wr_en, busy, wr_cmd_ready} !== 4'b0001) begin
        failures++;
        $display("FAIL mid_after_release c=%0d actual=%b required=0001 (rden,wr,busy,rdy)",
                 c, {wdf_rden, wr_en, busy, wr_cmd_ready});
      end
    end
    $display("test_reset_mid_burst done");
  endtask

  task automatic test_mask();
    fifo_flush();
    fifo_push({16'h6001, 16'h6002}, 4'b0110);
    fifo_push({16'h6003, 16'h6004}, 4'b1001);
    cfg_wl = 4'd2; cfg_bl8 = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      wr_cmd_valid = (c == 0);
      #1;
      if (c == 2 || c == 3 || c == 6) begin
        checks++;
        if ({mask_data_rise, mask_data_fall} !== ((c == 2) ? 4'b0110 : 4'b1001)) begin
          failures++;
          $display("FAIL mask c=%0d actual=%b", c, {mask_data_rise, mask_data_fall});
        end
      end
      if (c == 6) begin
        checks++;
        if ({wr_en, wr_data_rise} !== {1'b0, 16'h6003}) begin
          failures++;
          $display("FAIL mask_hold actual=%h required=06003", {wr_en, wr_data_rise});
        end
      end
      if (c == 8) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL mask_idle_busy actual=%b required=0", busy);
        end
      end
    end
    wr_cmd_valid = 1'b0;
    $display("test_mask done");
  endtask

  initial begin
    test_reset();
    test_basic_bl4();
    test_back_to_back();
    test_one_gap();
    test_underrun();
    test_reset_mid_burst();
    test_mask();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
